// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;
  localparam int FETCH_ADDR_W = 16;
  localparam int FETCH_INST_W = 16;
  localparam logic [FETCH_ADDR_W-1:0] RESET_PC = 16'h0000;
  localparam int PC_STEP = 2;

  typedef enum logic {FETCH, HALTED} fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction queue; flush clears occupancy but keeps stale payload.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);
  fetch_entry_t mem [2];
  logic wr_ptr, rd_ptr;

  // Push into a full queue is only legal alongside a pop: the slot being
  // overwritten is the head that leaves at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_valid = (count != 2'd0);
  assign head       = mem[rd_ptr];
endmodule

// File: rtl/fetch_controller.sv
// Owns the PC, issues one fetch per cycle to synchronous instruction memory,
// and queues returned instructions for decode.
module fetch_controller #(
  parameter int                ADDR_W    = fetch_pkg::FETCH_ADDR_W,
  parameter int                INST_W    = fetch_pkg::FETCH_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = fetch_pkg::RESET_PC,
  parameter int                PC_STEP   = fetch_pkg::PC_STEP,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic [INST_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              halted
);
  import fetch_pkg::*;

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc, inflight_pc;
  logic              inflight, issue, pop, head_valid;
  logic [1:0]        count;
  fetch_entry_t      head, cap;

  assign inst_valid = head_valid & ~redirect_valid;
  assign pop        = inst_valid & inst_ready;

  // count + inflight - pop < BUF_DEPTH, rearranged so nothing underflows
  assign issue = ~rst & (state == FETCH) & ~redirect_valid & ~halt &
                 (({1'b0, count} + {2'b0, inflight}) < (3'(BUF_DEPTH) + {2'b0, pop}));

  assign imem_addr = pc;
  assign imem_req  = issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      halted      <= 1'b0;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + ADDR_W'(PC_STEP);
      end
      if (redirect_valid) begin
        pc     <= redirect_pc & ~ADDR_W'(1);
        state  <= FETCH;
        halted <= 1'b0;
      end else if (state == FETCH && halt) begin
        state  <= HALTED;
        halted <= 1'b1;
      end
    end
  end

  assign cap.pc   = inflight_pc;
  assign cap.inst = imem_data;

  fetch_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight),
    .pop        (pop),
    .flush      (redirect_valid),
    .din        (cap),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign inst_out = head.inst;
  assign inst_pc  = head.pc;
endmodule

// File: tb/tb_fetch_controller.sv
// Directed stimulus with scoreboard queues; monitors pop expected entries on each handshake.
module tb_fetch_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT1: default RESET_PC
  logic        rst = 1'b1, redirect_valid = 1'b0, halt = 1'b0, inst_ready = 1'b0;
  logic [15:0] redirect_pc = '0, imem_addr, imem_data = '0, inst_out, inst_pc;
  logic        imem_req, inst_valid, halted;
  // DUT2: RESET_PC near the top of the address space
  logic        rst2 = 1'b1, redirect_valid2 = 1'b0, halt2 = 1'b0, inst_ready2 = 1'b0;
  logic [15:0] redirect_pc2 = '0, imem_addr2, imem_data2 = '0, inst_out2, inst_pc2;
  logic        imem_req2, inst_valid2, halted2;

  fetch_controller dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .halted(halted));

  fetch_controller #(.RESET_PC(16'hFFFC)) dut2 (
    .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_req(imem_req2), .imem_data(imem_data2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .halt(halt2),
    .inst_valid(inst_valid2), .inst_ready(inst_ready2), .inst_out(inst_out2), .inst_pc(inst_pc2),
    .halted(halted2));

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return 16'hA000 + {1'b0, a[15:1]};
  endfunction

  always @(posedge clk) begin
    imem_data  <= mem_val(imem_addr);
    imem_data2 <= mem_val(imem_addr2);
  end

  int checks = 0, failures = 0;
  logic [31:0] q1[$], q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && inst_valid && inst_ready) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1_extra_pop actual pc=%h inst=%h expected none", inst_pc, inst_out);
      end else begin
        e = q1.pop_front();
        chk("dut1_pc", {16'h0, inst_pc}, {16'h0, e[31:16]});
        chk("dut1_inst", {16'h0, inst_out}, {16'h0, e[15:0]});
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst2 && inst_valid2 && inst_ready2) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut2_extra_pop actual pc=%h inst=%h expected none", inst_pc2, inst_out2);
      end else begin
        e = q2.pop_front();
        chk("dut2_pc", {16'h0, inst_pc2}, {16'h0, e[31:16]});
        chk("dut2_inst", {16'h0, inst_out2}, {16'h0, e[15:0]});
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", inst_valid, 0);
    chk("rst_out", inst_out, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_halted", halted, 0);

    // Streaming with ready held high: 6 deliveries in cycles 2..7
    step(); rst = 1'b0; inst_ready = 1'b1;
    q1.push_back({16'h0000, 16'hA000}); q1.push_back({16'h0002, 16'hA001});
    q1.push_back({16'h0004, 16'hA002}); q1.push_back({16'h0006, 16'hA003});
    q1.push_back({16'h0008, 16'hA004}); q1.push_back({16'h000A, 16'hA005});
    @(negedge clk); chk("c0_addr", imem_addr, 16'h0000); chk("c0_req", imem_req, 1); chk("c0_valid", inst_valid, 0);
    step(); @(negedge clk); chk("c1_addr", imem_addr, 16'h0002); chk("c1_valid", inst_valid, 0);
    step(); @(negedge clk); chk("c2_addr", imem_addr, 16'h0004); chk("c2_valid", inst_valid, 1);
    repeat (5) step();
    step(); inst_ready = 1'b0; rst = 1'b1;
    @(negedge clk); chk("rst2_valid", inst_valid, 0); chk("rst2_addr", imem_addr, 16'h0000);

    // Backpressure: ready low in cycles 0..6, high from 7
    step(); rst = 1'b0;
    q1.push_back({16'h0000, 16'hA000}); q1.push_back({16'h0002, 16'hA001});
    q1.push_back({16'h0004, 16'hA002}); q1.push_back({16'h0006, 16'hA003});
    q1.push_back({16'h0008, 16'hA004});
    @(negedge clk); chk("bp_c0_req", imem_req, 1);
    step(); @(negedge clk); chk("bp_c1_req", imem_req, 1);
    for (int i = 2; i <= 6; i++) begin
      step(); @(negedge clk); chk("bp_stall_req", imem_req, 0);
    end
    step(); inst_ready = 1'b1;
    @(negedge clk); chk("bp_resume_req", imem_req, 1); chk("bp_resume_addr", imem_addr, 16'h0004);
    repeat (4) step();
    step(); inst_ready = 1'b0;                       // cycle 12: queue fills
    @(negedge clk); chk("c12_req", imem_req, 0);

    // Redirect with a full queue (cycle 13 = R)
    step(); redirect_valid = 1'b1; redirect_pc = 16'h0021;
    q1.push_back({16'h0020, 16'hA010}); q1.push_back({16'h0022, 16'hA011});
    q1.push_back({16'h0024, 16'hA012}); q1.push_back({16'h0026, 16'hA013});
    @(negedge clk); chk("R_valid", inst_valid, 0); chk("R_req", imem_req, 0);
    step(); redirect_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clk); chk("R1_addr", imem_addr, 16'h0020); chk("R1_req", imem_req, 1); chk("R1_valid", inst_valid, 0);
    step(); @(negedge clk); chk("R2_valid", inst_valid, 0);
    step(); @(negedge clk); chk("R3_valid", inst_valid, 1); chk("R3_out", inst_out, 16'hA010); chk("R3_pc", inst_pc, 16'h0020);
    step();

    // Halt at cycle 18; held high while HALTED and through the redirect
    step(); halt = 1'b1;
    @(negedge clk); chk("H_req", imem_req, 0);
    step(); @(negedge clk); chk("H1_halted", halted, 1); chk("H1_req", imem_req, 0);
    step(); @(negedge clk); chk("H2_valid", inst_valid, 0); chk("H2_halted", halted, 1);
    step();
    step(); redirect_valid = 1'b1; redirect_pc = 16'h0040;
    q1.push_back({16'h0040, 16'hA020}); q1.push_back({16'h0042, 16'hA021});
    q1.push_back({16'h0044, 16'hA022});
    @(negedge clk); chk("HR_halted", halted, 1); chk("HR_req", imem_req, 0);
    step(); redirect_valid = 1'b0; halt = 1'b0;
    @(negedge clk); chk("HR1_halted", halted, 0); chk("HR1_addr", imem_addr, 16'h0040); chk("HR1_req", imem_req, 1);
    step(); @(negedge clk); chk("HR2_valid", inst_valid, 0);
    step(); @(negedge clk); chk("HR3_valid", inst_valid, 1); chk("HR3_out", inst_out, 16'hA020);
    repeat (2) step();
    step(); inst_ready = 1'b0;

    // PC wrap and asynchronous reset on DUT2
    @(negedge clk); chk("w_rst_addr", imem_addr2, 16'hFFFC); chk("w_rst_req", imem_req2, 0);
    step(); rst2 = 1'b0; inst_ready2 = 1'b1;
    q2.push_back({16'hFFFC, 16'h1FFE}); q2.push_back({16'hFFFE, 16'h1FFF});
    q2.push_back({16'h0000, 16'hA000}); q2.push_back({16'h0002, 16'hA001});
    @(negedge clk); chk("w_c0_addr", imem_addr2, 16'hFFFC); chk("w_c0_req", imem_req2, 1);
    step(); @(negedge clk); chk("w_c1_addr", imem_addr2, 16'hFFFE);
    step(); @(negedge clk); chk("w_c2_addr", imem_addr2, 16'h0000);
    repeat (3) step();
    step(); chk("w_pre_rst_valid", inst_valid2, 1);
    rst2 = 1'b1; #1;
    chk("w_async_valid", inst_valid2, 0); chk("w_async_addr", imem_addr2, 16'hFFFC);
    step(); rst2 = 1'b0;
    q2.push_back({16'hFFFC, 16'h1FFE}); q2.push_back({16'hFFFE, 16'h1FFF});
    @(negedge clk); chk("w_restart_addr", imem_addr2, 16'hFFFC); chk("w_restart_req", imem_req2, 1);
    repeat (3) step();
    step(); inst_ready2 = 1'b0;
    step();
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
